ifu_fetch: RTL and testbench

Instruction-fetch stage that sits directly upstream of the combinational instruction ROM.
- Owns the architectural PC and drives it to the ROM.
- Captures the returned instruction into an IF/ID buffer and hands {pc, inst} to decode over a valid/ready handshake.
- Handles redirects (branch/jump) and stops fetching once an ebreak is fetched and consumed.

---
 rtl/npc_pkg.sv | 14 +
 rtl/ifu_fetch.sv | 114 +++++++++++
 tb/tb_ifu_fetch.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/npc_pkg.sv
// rtl/npc_pkg.sv - shared constants and fetch state encoding for the npc core
package npc_pkg;

    localparam logic [31:0] RESET_PC    = 32'h8000_0000;
    localparam logic [31:0] EBREAK_INST = 32'h0010_0073;
    localparam logic [31:0] NOP_INST    = 32'h0000_0013;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        HALT  = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/ifu_fetch.sv
// rtl/ifu_fetch.sv - instruction fetch stage: PC owner, IF/ID buffer, redirect and ebreak halt
module ifu_fetch
    import npc_pkg::*;
#(
    parameter int               XLEN     = 32,
    parameter logic [XLEN-1:0]  RESET_PC = npc_pkg::RESET_PC
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic [XLEN-1:0] imem_pc,
    input  logic [XLEN-1:0] imem_inst,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            id_valid,
    input  logic            id_ready,
    output logic [XLEN-1:0] id_pc,
    output logic [XLEN-1:0] id_inst,
    output logic            halted,
    output logic [31:0]     inst_cnt
);

    fetch_state_t    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic            valid_q, valid_d;
    logic [XLEN-1:0] id_pc_q, id_pc_d;
    logic [XLEN-1:0] id_inst_q, id_inst_d;
    logic            halted_q, halted_d;
    logic [31:0]     cnt_q;

    logic            fire;
    logic            can_load;
    logic            is_ebreak;
    logic [XLEN-1:0] target;

    assign fire      = valid_q & id_ready;
    assign can_load  = ~valid_q | id_ready;
    assign is_ebreak = (imem_inst == XLEN'(EBREAK_INST));
    assign target    = {redirect_pc[XLEN-1:2], 2'b00};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= RUN;
            pc_q      <= RESET_PC;
            valid_q   <= 1'b0;
            id_pc_q   <= '0;
            id_inst_q <= '0;
            halted_q  <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            valid_q   <= valid_d;
            id_pc_q   <= id_pc_d;
            id_inst_q <= id_inst_d;
            halted_q  <= halted_d;
            if (fire) begin
                cnt_q <= cnt_q + 32'd1;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        valid_d   = valid_q;
        id_pc_d   = id_pc_q;
        id_inst_d = id_inst_q;
        halted_d  = halted_q;
        unique case (state_q)
            RUN: begin
                // A redirect squashes whatever is buffered, even if decode takes it now.
                if (redirect_valid) begin
                    pc_d    = target;
                    valid_d = 1'b0;
                end else if (can_load) begin
                    id_pc_d   = pc_q;
                    id_inst_d = imem_inst;
                    valid_d   = 1'b1;
                    if (is_ebreak) begin
                        state_d = DRAIN;
                    end else begin
                        pc_d = pc_q + XLEN'(4);
                    end
                end
            end
            DRAIN: begin
                if (redirect_valid) begin
                    pc_d    = target;
                    valid_d = 1'b0;
                    state_d = RUN;
                end else if (fire) begin
                    valid_d  = 1'b0;
                    halted_d = 1'b1;
                    state_d  = HALT;
                end
            end
            HALT: begin
                valid_d  = 1'b0;
                halted_d = 1'b1;
            end
            default: begin
                state_d = RUN;
            end
        endcase
    end

    assign imem_pc  = pc_q;
    assign id_valid = valid_q;
    assign id_pc    = id_pc_q;
    assign id_inst  = id_inst_q;
    assign halted   = halted_q;
    assign inst_cnt = cnt_q;

endmodule

// File: tb/tb_ifu_fetch.sv
// tb/tb_ifu_fetch.sv - directed self-checking bench for ifu_fetch
module tb_ifu_fetch;

    logic        clk;
    logic        rst_n;
    logic [31:0] imem_pc;
    logic [31:0] imem_inst;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_pc;
    logic [31:0] id_inst;
    logic        halted;
    logic [31:0] inst_cnt;

    int vectors = 0;
    int errs    = 0;

    ifu_fetch #(.XLEN(32), .RESET_PC(32'h8000_0000)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_pc        (imem_pc),
        .imem_inst      (imem_inst),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .id_valid       (id_valid),
        .id_ready       (id_ready),
        .id_pc          (id_pc),
        .id_inst        (id_inst),
        .halted         (halted),
        .inst_cnt       (inst_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always_comb begin
        case (imem_pc)
            32'h8000_0000: imem_inst = 32'h0051_0093;
            32'h8000_0004: imem_inst = 32'h00A1_8113;
            32'h8000_0008: imem_inst = 32'h0020_8233;
            32'h8000_000C: imem_inst = 32'h0010_0073;
            default:       imem_inst = 32'h0000_0013;
        endcase
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_n          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        id_ready       = 1'b1;
        tick();
        tick();
        chk("rst_pc",     imem_pc,  32'h8000_0000);
        chk("rst_valid",  {31'b0, id_valid}, 32'd0);
        chk("rst_id_pc",  id_pc,    32'h0);
        chk("rst_inst",   id_inst,  32'h0);
        chk("rst_halted", {31'b0, halted}, 32'd0);
        chk("rst_cnt",    inst_cnt, 32'd0);
        rst_n = 1'b1;
        chk("rel_pc",     imem_pc,  32'h8000_0000);

        tick();
        chk("e1_valid",   {31'b0, id_valid}, 32'd1);
        chk("e1_id_pc",   id_pc,    32'h8000_0000);
        chk("e1_inst",    id_inst,  32'h0051_0093);
        tick();
        chk("e2_id_pc",   id_pc,    32'h8000_0004);
        chk("e2_inst",    id_inst,  32'h00A1_8113);
        chk("e2_cnt",     inst_cnt, 32'd1);

        id_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("bp_id_pc",   id_pc,    32'h8000_0004);
            chk("bp_inst",    id_inst,  32'h00A1_8113);
            chk("bp_imem_pc", imem_pc,  32'h8000_0008);
            chk("bp_cnt",     inst_cnt, 32'd1);
        end
        id_ready = 1'b1;
        tick();
        chk("bp_rel_id_pc", id_pc,    32'h8000_0008);
        chk("bp_rel_cnt",   inst_cnt, 32'd2);

        redirect_valid = 1'b1;
        redirect_pc    = 32'h8000_0102;
        tick();
        chk("rd_valid",   {31'b0, id_valid}, 32'd0);
        chk("rd_imem_pc", imem_pc,  32'h8000_0100);
        chk("rd_cnt",     inst_cnt, 32'd3);
        redirect_valid = 1'b0;
        tick();
        chk("rd_id_pc",   id_pc,    32'h8000_0100);
        chk("rd_valid2",  {31'b0, id_valid}, 32'd1);
        chk("rd_cnt2",    inst_cnt, 32'd3);

        redirect_valid = 1'b1;
        redirect_pc    = 32'h8000_0008;
        tick();
        redirect_valid = 1'b0;
        tick();
        chk("eb_pre_id_pc", id_pc, 32'h8000_0008);
        tick();
        chk("eb_id_pc",   id_pc,    32'h8000_000C);
        chk("eb_inst",    id_inst,  32'h0010_0073);
        chk("eb_imem_pc", imem_pc,  32'h8000_000C);
        chk("eb_cnt",     inst_cnt, 32'd5);
        id_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("eb_hold_valid",   {31'b0, id_valid}, 32'd1);
            chk("eb_hold_imem_pc", imem_pc, 32'h8000_000C);
            chk("eb_hold_halted",  {31'b0, halted}, 32'd0);
        end
        id_ready = 1'b1;
        tick();
        chk("halt_halted", {31'b0, halted}, 32'd1);
        chk("halt_valid",  {31'b0, id_valid}, 32'd0);
        chk("halt_cnt",    inst_cnt, 32'd6);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h8000_0000;
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("halt_rd_halted",  {31'b0, halted}, 32'd1);
            chk("halt_rd_valid",   {31'b0, id_valid}, 32'd0);
            chk("halt_rd_imem_pc", imem_pc, 32'h8000_000C);
            chk("halt_rd_cnt",     inst_cnt, 32'd6);
        end
        redirect_valid = 1'b0;

        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h8000_0008;
        tick();
        redirect_valid = 1'b0;
        tick();
        tick();
        chk("dr_id_inst", id_inst,  32'h0010_0073);
        chk("dr_cnt",     inst_cnt, 32'd1);
        id_ready       = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h8000_0000;
        tick();
        chk("dr_valid",   {31'b0, id_valid}, 32'd0);
        chk("dr_halted",  {31'b0, halted}, 32'd0);
        chk("dr_imem_pc", imem_pc,  32'h8000_0000);
        redirect_valid = 1'b0;
        id_ready       = 1'b1;
        tick();
        chk("dr_id_pc",   id_pc,    32'h8000_0000);
        chk("dr_valid2",  {31'b0, id_valid}, 32'd1);

        tick();
        chk("ar_pre_imem_pc", imem_pc, 32'h8000_0008);
        chk("ar_pre_valid",   {31'b0, id_valid}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_imem_pc", imem_pc,  32'h8000_0000);
        chk("ar_valid",   {31'b0, id_valid}, 32'd0);
        chk("ar_id_pc",   id_pc,    32'h0);
        chk("ar_cnt",     inst_cnt, 32'd0);
        chk("ar_halted",  {31'b0, halted}, 32'd0);
        rst_n = 1'b1;
        tick();
        chk("ar_rs_id_pc", id_pc,    32'h8000_0000);
        chk("ar_rs_cnt",   inst_cnt, 32'd0);
        tick();
        chk("ar_rs_id_pc2", id_pc,    32'h8000_0004);
        chk("ar_rs_cnt2",   inst_cnt, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule
